sp_ram_burst_ctrl: RTL and testbench
====================================

// Module: sp_ram_burst_ctrl
// PURPOSE
//   Initiator for the single-port RAM (sp_ram): drives its en/w_r/add/data_in pins and captures data_out.
//   Accepts burst commands (write or read, start address, length) over valid/ready.
//   Streams write beats in, or read beats out, with backpressure. Sits between a user datapath and sp_ram.
// PARAMETERS
//   DATA_WIDTH     8   RAM word width
//   ADDRESS_WIDTH  4   RAM address width
//   DEPTH          16  RAM words, <= 2**ADDRESS_WIDTH
//   LEN_WIDTH      4   burst length field width; beats = cmd_len+1 (1..2**LEN_WIDTH)
//   RD_LATENCY     1   cycles from read-issue edge to valid ram_data_out (>=1)
// PORTS
//   clk           in   1              clock, all logic on posedge
//   rst_n         in   1              synchronous reset, active-low
//   cmd_valid     in   1              command offered
//   cmd_ready     out  1              command accepted when valid&ready
//   cmd_wr        in   1              1=write burst, 0=read burst
//   cmd_addr      in   ADDRESS_WIDTH  start address
//   cmd_len       in   LEN_WIDTH      beats-1
//   wdata_valid   in   1              write beat offered
//   wdata_ready   out  1              write beat accepted when valid&ready
//   wdata         in   DATA_WIDTH     write beat data
//   rdata_valid   out  1              read beat available
//   rdata_ready   in   1              consumer takes beat when valid&ready
//   rdata         out  DATA_WIDTH     read beat data
//   rdata_last    out  1              marks final read beat of burst
//   busy          out  1              high in any state except IDLE
//   ram_en        out  1              -> sp_ram en
//   ram_w_r       out  1              -> sp_ram w_r (1=write, 0=read)
//   ram_add       out  ADDRESS_WIDTH  -> sp_ram add
//   ram_data_in   out  DATA_WIDTH     -> sp_ram data_in
//   ram_data_out  in   DATA_WIDTH     <- sp_ram data_out
// BEHAVIOUR
//   States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
//   Reset (rst_n=0 at posedge): state=IDLE, addr/beat counters=0, rdata=0; all outputs low
//     (cmd_ready=0 during reset cycle). Reset mid-burst abandons burst; no further RAM access, no beat emitted.
//   IDLE: cmd_ready=1. On accept latch addr=cmd_addr, remaining=cmd_len; -> WRITE if cmd_wr else RD_ISSUE.
//   WRITE: wdata_ready=1; ram_en=ram_w_r=wdata_valid, ram_add=addr, ram_data_in=wdata (combinational).
//     Each accepted beat: addr++, remaining--; beat with remaining==0 -> IDLE. Bubbles (wdata_valid=0) allowed, no RAM access.
//   RD_ISSUE: one cycle, ram_en=1, ram_w_r=0, ram_add=addr; -> RD_WAIT.
//   RD_WAIT: count RD_LATENCY-1 further cycles, then capture ram_data_out into rdata; -> RD_RESP.
//     Capture edge = RD_LATENCY posedges after the RD_ISSUE edge.
//   RD_RESP: rdata_valid=1, rdata/rdata_last stable until rdata_ready. On handshake: last -> IDLE,
//     else addr++, remaining--, -> RD_ISSUE. Read throughput: one beat per RD_LATENCY+2 cycles minimum.
//   ram_en=0 in IDLE, RD_WAIT, RD_RESP; ram_w_r=0 whenever not writing; ram_add/ram_data_in=0 when ram_en=0.
//   Address wrap: addr==DEPTH-1 increments to 0 (not to DEPTH); bursts longer than DEPTH revisit addresses.
//   cmd_ready=0 in all states but IDLE; new command accepted the cycle after the last beat completes, never same cycle.
//   wdata_ready=0 outside WRITE; rdata_valid=0 outside RD_RESP; rdata_last=rdata_valid & (remaining==0).
//   busy=(state!=IDLE). No error signalling; all cmd_addr/cmd_len values legal.
// TESTING
//   1 Reset: rst_n=0 3 cycles with cmd_valid=1 -> no accept, ram_en=0, all outputs 0; rst_n=1 -> cmd_ready=1 next cycle.
//   2 Write burst wr=1 addr=1 len=2, wdata ab,bc,cd -> ram_en&w_r three cycles, add 1,2,3; read burst addr=1 len=2 -> rdata ab,bc,cd, last on cd.
//   3 Wrap: write addr=15 len=1 (11,22) -> RAM writes add 15 then 0; read addr=15 len=1 returns 11,22.
//   4 Backpressure: read len=3, rdata_ready low 4 cycles on beat 1 -> rdata held stable, no new ram_en until handshake; order preserved.
//   5 Write bubbles: wdata_valid toggles 1,0,0,1 -> ram_en only on valid cycles, addresses contiguous, busy until last beat.
//   6 Reset mid-burst: rst_n=0 after 2 of 4 write beats -> IDLE, no further writes; 2 written words readable, others unchanged.

Source files
------------

// File: rtl/sp_ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sp_ram_burst_ctrl
//   Burst initiator for a single-port synchronous RAM. A command (write or
//   read, start address, beats-1) is accepted over a valid/ready handshake.
//   Write bursts stream beats from wdata_* straight onto the RAM pins. Read
//   bursts issue one RAM read per beat, wait RD_LATENCY cycles, register the
//   returned word and present it on rdata_* until the consumer takes it.
//
// Ports
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_wr, cmd_addr, cmd_len payload
//   wdata_valid/ready   write beat handshake; wdata payload
//   rdata_valid/ready   read beat handshake; rdata, rdata_last payload
//   busy                high whenever a burst is in progress
//   ram_en, ram_w_r,    RAM control/address/write-data pins
//   ram_add, ram_data_in
//   ram_data_out        RAM read data
// -----------------------------------------------------------------------------
module sp_ram_burst_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DEPTH         = 16,
  parameter int LEN_WIDTH     = 4,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rdata_last,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_w_r,
  output logic [ADDRESS_WIDTH-1:0] ram_add,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_RESP
  } state_e;

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]         LAT_LAST  = LAT_W'(RD_LATENCY - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
  logic [LEN_WIDTH-1:0]     rem_q,   rem_d;
  logic [LAT_W-1:0]         lat_q,   lat_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  // Address wraps at DEPTH, which need not be a power of two.
  logic [ADDRESS_WIDTH-1:0] addr_inc;
  assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRESS_WIDTH'(1);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    ram_en      = 1'b0;
    ram_w_r     = 1'b0;
    ram_add     = '0;
    ram_data_in = '0;

    // Outputs are forced low while reset is asserted so that a reset landing
    // mid-burst cannot complete a pending RAM write or hand out a beat.
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = cmd_wr ? S_WRITE : S_RD_ISSUE;
          end
        end

        S_WRITE: begin
          wdata_ready = 1'b1;
          if (wdata_valid) begin
            ram_en      = 1'b1;
            ram_w_r     = 1'b1;
            ram_add     = addr_q;
            ram_data_in = wdata;
            addr_d      = addr_inc;
            rem_d       = rem_q - LEN_WIDTH'(1);
            if (rem_q == '0) state_d = S_IDLE;
          end
        end

        S_RD_ISSUE: begin
          ram_en  = 1'b1;
          ram_add = addr_q;
          lat_d   = '0;
          state_d = S_RD_WAIT;
        end

        // Capture lands RD_LATENCY edges after the issue edge.
        S_RD_WAIT: begin
          if (lat_q == LAT_LAST) begin
            rdata_d = ram_data_out;
            state_d = S_RD_RESP;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end

        S_RD_RESP: begin
          rdata_valid = 1'b1;
          rdata_last  = (rem_q == '0);
          if (rdata_ready) begin
            if (rem_q == '0) begin
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_inc;
              rem_d   = rem_q - LEN_WIDTH'(1);
              state_d = S_RD_ISSUE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset; all
  // flops here are plain registers, so every one of them is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rst_n ? rdata_q : '0;
  assign busy  = rst_n && (state_q != S_IDLE);

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_burst_ctrl
//   Drives directed and random bursts into sp_ram_burst_ctrl attached to a
//   behavioural RAM. Expected RAM writes, RAM read addresses and read beats
//   are queued when stimulus is issued; a negedge monitor pops and compares
//   them whenever the DUT presents the corresponding event.
// -----------------------------------------------------------------------------
module tb_sp_ram_burst_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int LW     = 4;
  localparam int RD_LAT = 2;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_en, ram_w_r;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_data_in, ram_data_out;

  sp_ram_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH),
    .LEN_WIDTH(LW), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata(rdata), .rdata_last(rdata_last),
    .busy(busy),
    .ram_en(ram_en), .ram_w_r(ram_w_r), .ram_add(ram_add),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  logic          tb_init;
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] pipe [RD_LAT];
  assign ram_data_out = pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!tb_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 13 + 5);
    end else if (ram_en && ram_w_r) begin
      mem[ram_add] <= ram_data_in;
    end
    if (ram_en && !ram_w_r) pipe[0] <= mem[ram_add];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } rd_t;

  logic [DW-1:0] ref_mem [DEPTH];
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_raddr[$];
  rd_t           exp_rd[$];
  logic [DW-1:0] wbuf[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic          stall_q;
  logic [DW-1:0] held_data;
  logic          held_last;
  wr_t           w_got;
  rd_t           r_got;
  logic [AW-1:0] a_got;

  initial stall_q = 1'b0;

  always @(negedge clk) begin
    if (ram_en && ram_w_r) begin
      if (exp_wr.size() == 0) fail_now("unexpected_ram_write");
      else begin
        w_got = exp_wr.pop_front();
        check("ram_wr_addr", 32'(ram_add), 32'(w_got.addr));
        check("ram_wr_data", 32'(ram_data_in), 32'(w_got.data));
      end
    end
    if (ram_en && !ram_w_r) begin
      if (exp_raddr.size() == 0) fail_now("unexpected_ram_read");
      else begin
        a_got = exp_raddr.pop_front();
        check("ram_rd_addr", 32'(ram_add), 32'(a_got));
      end
    end
    if (rdata_valid) begin
      check("ram_idle_while_resp", 32'(ram_en), 32'(0));
      if (stall_q) begin
        check("rdata_stable", 32'(rdata), 32'(held_data));
        check("rdata_last_stable", 32'(rdata_last), 32'(held_last));
      end
      if (rdata_ready) begin
        if (exp_rd.size() == 0) fail_now("unexpected_read_beat");
        else begin
          r_got = exp_rd.pop_front();
          check("rdata", 32'(rdata), 32'(r_got.data));
          check("rdata_last", 32'(rdata_last), 32'(r_got.last));
        end
      end
    end
    stall_q   <= rdata_valid && !rdata_ready;
    held_data <= rdata;
    held_last <= rdata_last;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input int addr, input int len);
    int waited = 0;
    cmd_wr    = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    tick();
    cmd_valid = 1'b0;
    check("cmd_ready_low_in_burst", 32'(cmd_ready), 32'(0));
    check("busy_in_burst", 32'(busy), 32'(1));
    if (!wr) begin
      for (int i = 0; i <= len; i++) begin
        int a = (addr + i) % DEPTH;
        exp_raddr.push_back(AW'(a));
        exp_rd.push_back('{data: ref_mem[a], last: (i == len)});
      end
    end
  endtask

  // gap < 0 selects a random number of idle cycles between beats.
  task automatic write_burst(input int addr, input int len, input int gap);
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      int waited = 0;
      if (i > 0) begin
        for (int k = 0; k < g; k++) begin
          wdata_valid = 1'b0;
          tick();
          check("busy_in_bubble", 32'(busy), 32'(1));
          check("wdata_ready_in_bubble", 32'(wdata_ready), 32'(1));
        end
      end
      wdata_valid = 1'b1;
      wdata       = wbuf[i];
      while (!wdata_ready && waited < 50) begin
        tick();
        waited++;
      end
      if (!wdata_ready) fail_now("wdata_ready_timeout");
      exp_wr.push_back('{addr: AW'((addr + i) % DEPTH), data: wbuf[i]});
      ref_mem[(addr + i) % DEPTH] = wbuf[i];
      tick();
    end
    wdata_valid = 1'b0;
    check("idle_after_write", 32'(busy), 32'(0));
    check("cmd_ready_after_write", 32'(cmd_ready), 32'(1));
  endtask

  task automatic read_burst(input int addr, input int len, input int stall_beat,
                            input bit rand_ready);
    int got = 0, cyc = 0, stalled = 0;
    send_cmd(1'b0, addr, len);
    while (got <= len && cyc < 2000) begin
      if (rdata_valid) begin
        if (got == stall_beat && stalled < 4) begin
          rdata_ready = 1'b0;
          stalled++;
        end else if (rand_ready && $urandom_range(0, 1) == 0) begin
          rdata_ready = 1'b0;
        end else begin
          rdata_ready = 1'b1;
          got++;
        end
      end else begin
        rdata_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    rdata_ready = 1'b0;
    if (got <= len) fail_now("read_burst_timeout");
    check("idle_after_read", 32'(busy), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 13 + 5);
    tb_init     = 1'b0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b1;
    cmd_wr      = 1'b1;
    cmd_addr    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;

    // 1: reset with a command offered
    tick();
    tb_init = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
      check("rst_ram_en", 32'(ram_en), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_wdata_ready", 32'(wdata_ready), 32'(0));
      check("rst_rdata_valid", 32'(rdata_valid), 32'(0));
      check("rst_rdata", 32'(rdata), 32'(0));
      check("rst_ram_add", 32'(ram_add), 32'(0));
      if (c < 2) tick();
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'(1));
    check("no_accept_in_reset", 32'(busy), 32'(0));

    // 2: basic write then read-back
    wbuf = '{8'hab, 8'hbc, 8'hcd};
    write_burst(1, 2, 0);
    read_burst(1, 2, -1, 1'b0);

    // 3: address wrap
    wbuf = '{8'h11, 8'h22};
    write_burst(15, 1, 0);
    read_burst(15, 1, -1, 1'b0);

    // 4: read backpressure on beat 1
    read_burst(0, 3, 1, 1'b0);

    // 5: write bubbles (valid 1,0,0,1)
    wbuf = '{8'h5a, 8'ha5};
    write_burst(6, 1, 2);
    read_burst(6, 1, -1, 1'b0);

    // 6: reset after 2 of 4 write beats
    send_cmd(1'b1, 9, 3);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata       = DW'(8'hc0 + i);
      exp_wr.push_back('{addr: AW'(9 + i), data: DW'(8'hc0 + i)});
      ref_mem[9 + i] = DW'(8'hc0 + i);
      tick();
    end
    wdata       = 8'hee;
    rst_n       = 1'b0;
    tick();
    check("midrst_ram_en", 32'(ram_en), 32'(0));
    wdata_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_idle", 32'(busy), 32'(0));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    read_burst(8, 5, -1, 1'b0);

    // random traffic
    for (int n = 0; n < 25; n++) begin
      int a = int'($urandom_range(0, DEPTH - 1));
      int l = int'($urandom_range(0, (1 << LW) - 1));
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        for (int i = 0; i <= l; i++) wbuf.push_back(DW'($urandom));
        write_burst(a, l, -1);
      end else begin
        read_burst(a, l, int'($urandom_range(0, l)), 1'b1);
      end
    end

    repeat (5) tick();
    check("pending_ram_writes", 32'(exp_wr.size()), 32'(0));
    check("pending_ram_reads", 32'(exp_raddr.size()), 32'(0));
    check("pending_read_beats", 32'(exp_rd.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
